// File: rtl/sobel_pkg.sv
// Shared widths and FSM encoding for the Sobel 3x3 window generator.
package sobel_pkg;

  localparam int PIXEL_W  = 8;
  localparam int WIN_SIZE = 3;
  localparam int WIN_W    = PIXEL_W * WIN_SIZE * WIN_SIZE;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel delay: read-before-write RAM addressed by the column counter.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 512,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_en,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [PIXEL_W-1:0] i_wr_data,
  output logic [PIXEL_W-1:0] o_rd_data
);

  logic [PIXEL_W-1:0] mem [DEPTH];

  // The read returns the value stored one line ago, before this cycle's write lands.
  assign o_rd_data = mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      mem[i_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream to 3x3 window generator for a Sobel stage.
// Optional o_frame_done pulse is built when SOBEL_FRAME_DONE_EN is defined.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [PIXEL_W-1:0] i_pixel_data,
  input  logic               i_pixel_data_valid,
  output logic [WIN_W-1:0]   o_pixel_data,
`ifdef SOBEL_FRAME_DONE_EN
  output logic               o_frame_done,
`endif
  output logic               o_pixel_data_valid
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  state_t             state;
  logic [PIXEL_W-1:0] line1_data;
  logic [PIXEL_W-1:0] line2_data;
  logic               last_col;
  logic               last_pixel;

  // win[r][c] packs so that byte 3*r+c sits at bits [8k+7:8k].
  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][PIXEL_W-1:0] win;

  assign last_col     = (col == COL_LAST);
  assign last_pixel   = last_col && (row == ROW_LAST);
  assign o_pixel_data = win;

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
    .i_clk     (i_clk),
    .i_en      (i_pixel_data_valid),
    .i_addr    (col),
    .i_wr_data (i_pixel_data),
    .o_rd_data (line1_data)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_line2 (
    .i_clk     (i_clk),
    .i_en      (i_pixel_data_valid),
    .i_addr    (col),
    .i_wr_data (line1_data),
    .o_rd_data (line2_data)
  );

  // RUN covers rows 2..IMG_HEIGHT-1, so a window is only emitted once two fresh lines exist.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col                <= '0;
      row                <= '0;
      state              <= FILL;
      o_pixel_data_valid <= 1'b0;
    end else begin
      o_pixel_data_valid <= i_pixel_data_valid && (state == RUN) && (col >= COL_W'(2));
      if (i_pixel_data_valid) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) begin
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end
        case (state)
          FILL:    if ((row == ROW_W'(2)) && (col == '0)) state <= RUN;
          RUN:     if (last_pixel) state <= FILL;
          default: state <= FILL;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      win <= '0;
    end else if (i_pixel_data_valid) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= line2_data;
      win[1][2] <= line1_data;
      win[2][2] <= i_pixel_data;
    end
  end

`ifdef SOBEL_FRAME_DONE_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= i_pixel_data_valid && last_pixel;
    end
  end
`endif

endmodule
